// File: rtl/mrc_sign_resolver.sv
// -----------------------------------------------------------------------------
// mrc_sign_resolver
//
// Terminal stage of the dual positive/negative modulus-compare chain.
// Every operand issued into the chain is tagged. A {valid, tag} delay line
// brings that tag back into line with the final 2-bit compare codes. The
// aligned pair is classified into POS / NEG / OVF / ERR. Classified results
// are queued in a show-ahead FIFO behind a valid/ready output port.
// Saturating ERR/OVF event counters and a sticky drop flag report to the host.
//
// Handshake: a result leaves the FIFO on every rising edge where
// out_valid && out_ready. While out_valid is high and out_ready is low,
// out_class and out_tag hold steady. The chain itself cannot be stalled.
// A classified result that finds the FIFO full, with no pop in the same
// cycle, is lost and sets drop_sticky.
//
// Ports
//   clk            in   1      rising-edge clock
//   reset_n        in   1      asynchronous active-low reset
//   issue_valid    in   1      first compare stage takes an operand this cycle
//   issue_tag      in   TAG_W  tag travelling with that operand
//   sign_result_A  in   2      final code vs positive bound P
//   sign_result_B  in   2      final code vs negative bound N (P < N)
//   out_valid      out  1      FIFO head valid
//   out_ready      in   1      consumer takes the head on out_valid & out_ready
//   out_class      out  2      00 POS, 01 NEG, 10 OVF, 11 ERR
//   out_tag        out  TAG_W  tag of the head entry
//   fifo_full      out  1      FIFO holds DEPTH entries
//   drop_sticky    out  1      a result was lost to a full FIFO
//   clear_stats    in   1      synchronous clear of counters and drop_sticky
//   err_count      out  CNT_W  saturating count of ERR classifications
//   ovf_count      out  CNT_W  saturating count of OVF classifications
// -----------------------------------------------------------------------------
module mrc_sign_resolver #(
    parameter int PIPE_LAT = 9,
    parameter int TAG_W    = 4,
    parameter int DEPTH    = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             issue_valid,
    input  logic [TAG_W-1:0] issue_tag,
    input  logic [1:0]       sign_result_A,
    input  logic [1:0]       sign_result_B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_class,
    output logic [TAG_W-1:0] out_tag,
    output logic             fifo_full,
    output logic             drop_sticky,
    input  logic             clear_stats,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] ovf_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = TAG_W + 2;

    localparam logic [1:0] CLS_POS = 2'b00;
    localparam logic [1:0] CLS_NEG = 2'b01;
    localparam logic [1:0] CLS_OVF = 2'b10;
    localparam logic [1:0] CLS_ERR = 2'b11;

    // Compare code encoding.
    localparam logic [1:0] CMP_EQ  = 2'b00;
    localparam logic [1:0] CMP_LT  = 2'b01;
    localparam logic [1:0] CMP_GT  = 2'b10;
    localparam logic [1:0] CMP_BAD = 2'b11;

    localparam logic [AW-1:0]    PTR_ONE    = AW'(1);
    localparam logic [AW:0]      COUNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]      COUNT_FULL = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    // -------------------------------------------------------------------------
    // Delay line: stage k holds an issue made k+1 cycles ago. The last stage
    // therefore lines up with the compare codes arriving PIPE_LAT cycles after
    // the issue. Reset clears every valid, so codes that belong to pre-reset
    // issues are never looked at.
    // -------------------------------------------------------------------------
    logic [PIPE_LAT-1:0] r_dl_valid;
    logic [TAG_W-1:0]    r_dl_tag [PIPE_LAT];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dl_valid <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                r_dl_tag[i] <= '0;
            end
        end else begin
            r_dl_valid[0] <= issue_valid;
            r_dl_tag[0]   <= issue_tag;
            for (int i = 1; i < PIPE_LAT; i++) begin
                r_dl_valid[i] <= r_dl_valid[i-1];
                r_dl_tag[i]   <= r_dl_tag[i-1];
            end
        end
    end

    logic             w_al_valid;
    logic [TAG_W-1:0] w_al_tag;

    assign w_al_valid = r_dl_valid[PIPE_LAT-1];
    assign w_al_tag   = r_dl_tag[PIPE_LAT-1];

    // -------------------------------------------------------------------------
    // Classification.
    // A in {EQ,LT} means X <= P. B in {EQ,GT} means X >= N.
    // Both true at once is impossible when P < N, so that case is reported
    // as ERR, just like a corrupt code.
    // -------------------------------------------------------------------------
    logic       w_le_p;
    logic       w_ge_n;
    logic       w_corrupt;
    logic [1:0] w_class;

    assign w_le_p    = (sign_result_A == CMP_EQ) || (sign_result_A == CMP_LT);
    assign w_ge_n    = (sign_result_B == CMP_EQ) || (sign_result_B == CMP_GT);
    assign w_corrupt = (sign_result_A == CMP_BAD) || (sign_result_B == CMP_BAD);

    always_comb begin
        w_class = CLS_ERR;
        if (w_corrupt) begin
            w_class = CLS_ERR;
        end else if (w_le_p && !w_ge_n) begin
            w_class = CLS_POS;
        end else if (!w_le_p && w_ge_n) begin
            w_class = CLS_NEG;
        end else if (!w_le_p && !w_ge_n) begin
            w_class = CLS_OVF;
        end else begin
            w_class = CLS_ERR;
        end
    end

    logic w_inc_err;
    logic w_inc_ovf;

    assign w_inc_err = w_al_valid && (w_class == CLS_ERR);
    assign w_inc_ovf = w_al_valid && (w_class == CLS_OVF);

    logic             r_cls_valid;
    logic [1:0]       r_cls_class;
    logic [TAG_W-1:0] r_cls_tag;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cls_valid <= 1'b0;
            r_cls_class <= 2'b00;
            r_cls_tag   <= '0;
        end else begin
            r_cls_valid <= w_al_valid;
            if (w_al_valid) begin
                r_cls_class <= w_class;
                r_cls_tag   <= w_al_tag;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Result FIFO: show-ahead, with no bypass from the classify register.
    // out_valid and fifo_full are registered copies derived from the next
    // occupancy. A pop in the same cycle frees a slot, so a push into a
    // full FIFO then still succeeds.
    // -------------------------------------------------------------------------
    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          r_out_valid;
    logic          r_full;

    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [AW:0]   w_count_nxt;
    logic [EW-1:0] w_head;

    assign w_pop  = r_out_valid && out_ready;
    assign w_push = r_cls_valid && (!r_full || w_pop);
    assign w_drop = r_cls_valid && r_full && !w_pop;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + COUNT_ONE;
            2'b01:   w_count_nxt = r_count - COUNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {r_cls_class, r_cls_tag};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_full      <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            r_count     <= w_count_nxt;
            r_out_valid <= (w_count_nxt != '0);
            r_full      <= (w_count_nxt == COUNT_FULL);
        end
    end

    // The storage array is not reset. The head is therefore masked to zero
    // while empty, so the outputs read 0 out of reset.
    assign w_head    = r_mem[r_rptr];
    assign out_valid = r_out_valid;
    assign fifo_full = r_full;
    assign out_class = r_out_valid ? w_head[EW-1:TAG_W] : 2'b00;
    assign out_tag   = r_out_valid ? w_head[TAG_W-1:0] : '0;

    // -------------------------------------------------------------------------
    // Host statistics. The counters count classifications, not FIFO writes,
    // so a dropped ERR/OVF is still counted. clear_stats beats a same-cycle
    // increment. A same-cycle drop beats clear_stats on the sticky flag, so
    // a loss is never hidden.
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] r_err_cnt;
    logic [CNT_W-1:0] r_ovf_cnt;
    logic             r_drop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_cnt <= '0;
            r_ovf_cnt <= '0;
        end else if (clear_stats) begin
            r_err_cnt <= '0;
            r_ovf_cnt <= '0;
        end else begin
            if (w_inc_err && !(&r_err_cnt)) begin
                r_err_cnt <= r_err_cnt + CNT_ONE;
            end
            if (w_inc_ovf && !(&r_ovf_cnt)) begin
                r_ovf_cnt <= r_ovf_cnt + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_drop <= 1'b0;
        end else if (w_drop) begin
            r_drop <= 1'b1;
        end else if (clear_stats) begin
            r_drop <= 1'b0;
        end
    end

    assign err_count   = r_err_cnt;
    assign ovf_count   = r_ovf_cnt;
    assign drop_sticky = r_drop;

endmodule

// File: tb/tb_mrc_sign_resolver.sv
`timescale 1ns/1ps
module tb_mrc_sign_resolver;

    localparam int PIPE_LAT = 9;
    localparam int TAG_W    = 4;
    localparam int DEPTH    = 8;
    localparam int CNT_W    = 4;   // narrow so saturation is reachable
    localparam int CNT_MAX  = (1 << CNT_W) - 1;
    localparam int TAG_MAX  = (1 << TAG_W) - 1;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             reset_n;
    logic             issue_valid;
    logic [TAG_W-1:0] issue_tag;
    logic [1:0]       sign_result_A;
    logic [1:0]       sign_result_B;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_class;
    logic [TAG_W-1:0] out_tag;
    logic             fifo_full;
    logic             drop_sticky;
    logic             clear_stats;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] ovf_count;

    always #5 clk = ~clk;

    mrc_sign_resolver #(
        .PIPE_LAT(PIPE_LAT),
        .TAG_W   (TAG_W),
        .DEPTH   (DEPTH),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .issue_valid  (issue_valid),
        .issue_tag    (issue_tag),
        .sign_result_A(sign_result_A),
        .sign_result_B(sign_result_B),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_class    (out_class),
        .out_tag      (out_tag),
        .fifo_full    (fifo_full),
        .drop_sticky  (drop_sticky),
        .clear_stats  (clear_stats),
        .err_count    (err_count),
        .ovf_count    (ovf_count)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int               due;
        logic [TAG_W-1:0] tag;
    } pend_t;

    typedef struct {
        int               at;
        logic [1:0]       cls;
        logic [TAG_W-1:0] tag;
    } arr_t;

    pend_t              pend_q[$];   // issued ops waiting for their codes
    arr_t               arr_q[$];    // classified, waiting to enter the FIFO
    logic [TAG_W+1:0]   exp_q[$];    // expected FIFO contents {class, tag}
    int                 m_err;
    int                 m_ovf;
    bit                 m_drop;

    // Classification from the bound relations (P < N).
    function automatic logic [1:0] ref_class(input logic [1:0] a, input logic [1:0] b);
        bit le_p;
        bit ge_n;
        if (a == 2'b11 || b == 2'b11) return 2'b11;
        le_p = (a == 2'b00) || (a == 2'b01);
        ge_n = (b == 2'b00) || (b == 2'b10);
        if (le_p && ge_n) return 2'b11;
        if (le_p) return 2'b00;
        if (ge_n) return 2'b01;
        return 2'b10;
    endfunction

    task automatic model_reset();
        pend_q.delete();
        arr_q.delete();
        exp_q.delete();
        m_err  = 0;
        m_ovf  = 0;
        m_drop = 0;
    endtask

    // Advances the model by one clock edge using the inputs of this cycle.
    task automatic model_cycle(input logic iv, input logic [TAG_W-1:0] tg,
                               input logic [1:0] a, input logic [1:0] b,
                               input logic rdy, input logic clr);
        bit         pop;
        bit         drop;
        arr_t       e;
        logic [1:0] c;
        pop  = (exp_q.size() > 0) && rdy;
        drop = 0;
        if (pop) void'(exp_q.pop_front());
        if (arr_q.size() > 0 && arr_q[0].at == cyc) begin
            e = arr_q.pop_front();
            if (exp_q.size() < DEPTH) exp_q.push_back({e.cls, e.tag});
            else drop = 1;
        end
        if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
            c = ref_class(a, b);
            arr_q.push_back('{at: cyc + 1, cls: c, tag: pend_q[0].tag});
            void'(pend_q.pop_front());
            if (!clr) begin
                if (c == 2'b11 && m_err < CNT_MAX) m_err++;
                if (c == 2'b10 && m_ovf < CNT_MAX) m_ovf++;
            end
        end
        if (clr) begin
            m_err = 0;
            m_ovf = 0;
        end
        if (drop) m_drop = 1;
        else if (clr) m_drop = 0;
        if (iv) pend_q.push_back('{due: cyc + PIPE_LAT, tag: tg});
        cyc++;
    endtask

    task automatic check_outputs();
        logic [TAG_W+1:0] h;
        chk("out_valid",   32'(out_valid),   32'(exp_q.size() > 0));
        chk("fifo_full",   32'(fifo_full),   32'(exp_q.size() == DEPTH));
        chk("drop_sticky", 32'(drop_sticky), 32'(m_drop));
        chk("err_count",   32'(err_count),   32'(m_err));
        chk("ovf_count",   32'(ovf_count),   32'(m_ovf));
        if (exp_q.size() > 0) begin
            h = exp_q[0];
            chk("out_class", 32'(out_class), 32'(h[TAG_W+1:TAG_W]));
            chk("out_tag",   32'(out_tag),   32'(h[TAG_W-1:0]));
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge: check the current cycle, drive it, advance.
    task automatic step(input logic iv, input logic [TAG_W-1:0] tg,
                        input logic [1:0] a, input logic [1:0] b,
                        input logic rdy, input logic clr);
        check_outputs();
        issue_valid   = iv;
        issue_tag     = tg;
        sign_result_A = a;
        sign_result_B = b;
        out_ready     = rdy;
        clear_stats   = clr;
        model_cycle(iv, tg, a, b, rdy, clr);
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [1:0] rnd2();
        return 2'($urandom_range(0, 3));
    endfunction

    task automatic idle(input logic rdy);
        step(1'b0, '0, rnd2(), rnd2(), rdy, 1'b0);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_out_valid"}, 32'(out_valid),   32'd0);
        chk({name, "_fifo_full"}, 32'(fifo_full),   32'd0);
        chk({name, "_drop"},      32'(drop_sticky), 32'd0);
        chk({name, "_err"},       32'(err_count),   32'd0);
        chk({name, "_ovf"},       32'(ovf_count),   32'd0);
        chk({name, "_class"},     32'(out_class),   32'd0);
        chk({name, "_tag"},       32'(out_tag),     32'd0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] cls;
    } vec_t;

    vec_t tbl[16];

    initial begin
        int         t0;
        int         seen;
        int         nxt;
        int         rdy_pct;
        bit         stale;
        logic [1:0] va;
        logic [1:0] vb;

        tbl[0]  = '{2'b00, 2'b00, 2'b11};
        tbl[1]  = '{2'b00, 2'b01, 2'b00};
        tbl[2]  = '{2'b00, 2'b10, 2'b11};
        tbl[3]  = '{2'b00, 2'b11, 2'b11};
        tbl[4]  = '{2'b01, 2'b00, 2'b11};
        tbl[5]  = '{2'b01, 2'b01, 2'b00};
        tbl[6]  = '{2'b01, 2'b10, 2'b11};
        tbl[7]  = '{2'b01, 2'b11, 2'b11};
        tbl[8]  = '{2'b10, 2'b00, 2'b01};
        tbl[9]  = '{2'b10, 2'b01, 2'b10};
        tbl[10] = '{2'b10, 2'b10, 2'b01};
        tbl[11] = '{2'b10, 2'b11, 2'b11};
        tbl[12] = '{2'b11, 2'b00, 2'b11};
        tbl[13] = '{2'b11, 2'b01, 2'b11};
        tbl[14] = '{2'b11, 2'b10, 2'b11};
        tbl[15] = '{2'b11, 2'b11, 2'b11};

        reset_n       = 1'b0;
        issue_valid   = 1'b0;
        issue_tag     = '0;
        sign_result_A = 2'b00;
        sign_result_B = 2'b00;
        out_ready     = 1'b0;
        clear_stats   = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset_n = 1'b1;
        repeat (2) idle(1'b1);

        // Single op: latency PIPE_LAT+2, class POS, tag 3.
        t0 = cyc;
        step(1'b1, 4'd3, rnd2(), rnd2(), 1'b0, 1'b0);
        for (int k = 1; k < PIPE_LAT; k++) idle(1'b0);
        step(1'b0, '0, 2'b01, 2'b01, 1'b0, 1'b0);
        chk("t1_early_valid", 32'(out_valid), 32'd0);
        idle(1'b0);
        chk("t1_latency", 32'(cyc - t0), 32'(PIPE_LAT + 2));
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_class", 32'(out_class), 32'd0);
        chk("t1_tag",   32'(out_tag),   32'd3);
        idle(1'b0);
        chk("t1_hold_class", 32'(out_class), 32'd0);
        chk("t1_hold_tag",   32'(out_tag),   32'd3);
        idle(1'b1);
        idle(1'b1);

        // All 16 code pairs, twice. The second pass drives err_count into saturation.
        step(1'b0, '0, rnd2(), rnd2(), 1'b1, 1'b1);
        for (int pass = 0; pass < 2; pass++) begin
            seen = 0;
            for (int j = 0; j < 16 + PIPE_LAT + 4; j++) begin
                va = rnd2();
                vb = rnd2();
                if (j >= PIPE_LAT && j - PIPE_LAT < 16) begin
                    va = tbl[j - PIPE_LAT].a;
                    vb = tbl[j - PIPE_LAT].b;
                end
                if (out_valid) begin
                    chk("tbl_class", 32'(out_class), 32'(tbl[out_tag].cls));
                    seen++;
                end
                step(j < 16, TAG_W'(j), va, vb, 1'b1, 1'b0);
            end
            chk("tbl_seen", 32'(seen), 32'd16);
            chk("tbl_err", 32'(err_count), (pass == 0) ? 32'd11 : 32'(CNT_MAX));
            chk("tbl_ovf", 32'(ovf_count), (pass == 0) ? 32'd1 : 32'd2);
        end

        // Overfill: 9 issues with out_ready low, the 9th is dropped.
        step(1'b0, '0, rnd2(), rnd2(), 1'b1, 1'b1);
        for (int j = 0; j < 9 + PIPE_LAT + 4; j++) begin
            va = rnd2();
            vb = rnd2();
            if (j >= PIPE_LAT) begin
                va = 2'b01;
                vb = 2'b01;
            end
            step(j < 9, TAG_W'(j), va, vb, 1'b0, 1'b0);
        end
        chk("ovf_fill_full", 32'(fifo_full),   32'd1);
        chk("ovf_fill_drop", 32'(drop_sticky), 32'd1);
        nxt = 0;
        for (int j = 0; j < DEPTH + 3; j++) begin
            if (out_valid) begin
                chk("drain_tag", 32'(out_tag), 32'(nxt));
                nxt++;
            end
            idle(1'b1);
        end
        chk("drain_count", 32'(nxt), 32'(DEPTH));

        // Full FIFO, pop in the same cycle as the 9th push: no drop.
        step(1'b0, '0, rnd2(), rnd2(), 1'b1, 1'b1);
        for (int j = 0; j < 9 + PIPE_LAT + 3; j++) begin
            va = rnd2();
            vb = rnd2();
            if (j >= PIPE_LAT && j < 9 + PIPE_LAT) begin
                va = 2'b10;
                vb = 2'b00;
            end
            step(j < 9, TAG_W'(j), va, vb, j == 8 + PIPE_LAT + 1, 1'b0);
        end
        chk("pp_full", 32'(fifo_full),   32'd1);
        chk("pp_drop", 32'(drop_sticky), 32'd0);
        nxt = 1;
        for (int j = 0; j < DEPTH + 3; j++) begin
            if (out_valid) begin
                chk("pp_tag",   32'(out_tag),   32'(nxt));
                chk("pp_class", 32'(out_class), 32'd1);
                nxt++;
            end
            idle(1'b1);
        end
        chk("pp_drain_count", 32'(nxt - 1), 32'(DEPTH));

        // Randomized traffic with shifting backpressure and occasional clears.
        rdy_pct = 50;
        for (int j = 0; j < 3000; j++) begin
            if (j % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0:       rdy_pct = 15;
                    1:       rdy_pct = 50;
                    default: rdy_pct = 95;
                endcase
            end
            step($urandom_range(0, 9) < 7, TAG_W'($urandom_range(0, TAG_MAX)),
                 rnd2(), rnd2(), $urandom_range(0, 99) < rdy_pct,
                 $urandom_range(0, 99) < 2);
        end

        // Reset with ops in flight: outputs clear, stale codes are ignored.
        for (int j = 0; j < 5; j++) begin
            step(1'b1, TAG_W'(j), rnd2(), rnd2(), 1'b0, 1'b0);
        end
        reset_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        stale = 0;
        for (int j = 0; j < PIPE_LAT + 10; j++) begin
            if (out_valid) stale = 1;
            idle($urandom_range(0, 1) == 1);
        end
        chk("stale_out_valid", 32'(stale), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
